// File: rtl/sfx_pkg.sv
// Shared types and constants for the dino sound-effect sequencer.
package sfx_pkg;

  localparam int HP_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ID_NONE     = 2'd0,
    ID_JUMP     = 2'd1,
    ID_POINT    = 2'd2,
    ID_GAMEOVER = 2'd3
  } sfx_id_e;

  // Half-periods in CLOCK_50 cycles; zero marks end of effect.
  localparam logic [HP_W-1:0] HP_JUMP_0  = 18'd55555;   // 450 Hz
  localparam logic [HP_W-1:0] HP_JUMP_1  = 18'd55555;   // 450 Hz
  localparam logic [HP_W-1:0] HP_POINT_0 = 18'd37878;   // 660 Hz
  localparam logic [HP_W-1:0] HP_POINT_1 = 18'd28409;   // 880 Hz
  localparam logic [HP_W-1:0] HP_GO_0    = 18'd56818;   // 440 Hz
  localparam logic [HP_W-1:0] HP_GO_1    = 18'd75757;   // 330 Hz
  localparam logic [HP_W-1:0] HP_GO_2    = 18'd113636;  // 220 Hz
  localparam logic [HP_W-1:0] HP_END     = 18'd0;

  // Pending bit layout: [2] gameover, [1] point, [0] jump.
  function automatic sfx_id_e highest_pending(input logic [2:0] pend);
    if (pend[2])      return ID_GAMEOVER;
    else if (pend[1]) return ID_POINT;
    else if (pend[0]) return ID_JUMP;
    else              return ID_NONE;
  endfunction

  function automatic logic [2:0] id_mask(input sfx_id_e id);
    case (id)
      ID_JUMP:     return 3'b001;
      ID_POINT:    return 3'b010;
      ID_GAMEOVER: return 3'b100;
      default:     return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// Square-wave phase generator: half-period counter plus phase flop.
module sfx_tone_gen
  import sfx_pkg::*;
(
  input  logic            CLOCK_50,
  input  logic            reset,
  input  logic            clear,
  input  logic            load,
  input  logic            enable,
  input  logic [HP_W-1:0] half_period_in,
  output logic            phase_next
);

  logic [HP_W-1:0] half_q, half_d;
  logic [HP_W-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;

  // Next tone state: clear dominates load, load dominates counting.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    half_d  = half_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clear) begin
      half_d  = '0;
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (load) begin
      half_d  = half_period_in;
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (enable) begin
      if (cnt_q == half_q - HP_W'(1)) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + HP_W'(1);
      end
    end
  end

  // Tone registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      half_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_next = phase_d;

endmodule

// File: rtl/dino_sfx_sequencer.sv
// Sound-effect scheduler: pending requests, fixed-priority arbiter,
// effect ROM and note sequencer driving the Audio_Controller sample path.
module dino_sfx_sequencer
  import sfx_pkg::*;
#(
  parameter logic [31:0] AMPLITUDE   = 32'd10000000,
  parameter int          NOTE_CYCLES = 2_500_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        mute,
  input  logic        req_jump,
  input  logic        req_point,
  input  logic        req_gameover,
  input  logic        audio_out_allowed,
  output logic [31:0] sample,
  output logic        write_audio_out,
  output logic        busy,
  output logic [1:0]  active_id
);

  localparam int          NW      = (NOTE_CYCLES > 1) ? $clog2(NOTE_CYCLES) : 1;
  localparam logic [31:0] NEG_AMP = ~AMPLITUDE + 32'd1;

  state_e          state_q, state_d;
  sfx_id_e         active_q, active_d;
  logic [1:0]      slot_q, slot_d;
  logic [NW-1:0]   note_q, note_d;
  logic [2:0]      pending_q, pending_d;
  logic [31:0]     sample_q, sample_d;
  logic [HP_W-1:0] rom_half;
  logic            tone_clear, tone_load, tone_enable, phase_next;

  // Effect ROM lookup for the current effect and slot.
  always_comb begin
    rom_half = HP_END;
    case (active_q)
      ID_JUMP: case (slot_q)
        2'd0:    rom_half = HP_JUMP_0;
        2'd1:    rom_half = HP_JUMP_1;
        default: rom_half = HP_END;
      endcase
      ID_POINT: case (slot_q)
        2'd0:    rom_half = HP_POINT_0;
        2'd1:    rom_half = HP_POINT_1;
        default: rom_half = HP_END;
      endcase
      ID_GAMEOVER: case (slot_q)
        2'd0:    rom_half = HP_GO_0;
        2'd1:    rom_half = HP_GO_1;
        2'd2:    rom_half = HP_GO_2;
        default: rom_half = HP_END;
      endcase
      default: rom_half = HP_END;
    endcase
  end

  // Pending bits: cleared when slot 0 of the effect is loaded; a new request wins.
  always_comb begin
    pending_d = pending_q;
    if (state_q == ST_LOAD && slot_q == 2'd0) pending_d = pending_d & ~id_mask(active_q);
    pending_d = pending_d | {req_gameover, req_point, req_jump};
  end

  // Next-state logic: arbitration, note sequencing and gameover preemption.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    slot_d      = slot_q;
    note_d      = note_q;
    tone_clear  = 1'b0;
    tone_load   = 1'b0;
    tone_enable = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tone_clear = 1'b1;
        note_d     = '0;
        if (|pending_q) begin
          state_d  = ST_LOAD;
          active_d = highest_pending(pending_q);
          slot_d   = 2'd0;
        end
      end
      ST_LOAD: begin
        if (rom_half == HP_END || slot_q == 2'd3) begin
          slot_d = 2'd0;
          if (|pending_q) begin
            state_d  = ST_LOAD;
            active_d = highest_pending(pending_q);
          end else begin
            state_d  = ST_IDLE;
            active_d = ID_NONE;
          end
        end else begin
          tone_load = 1'b1;
          note_d    = '0;
          state_d   = ST_PLAY;
        end
      end
      ST_PLAY: begin
        tone_enable = 1'b1;
        note_d      = note_q + NW'(1);
        if (req_gameover && active_q != ID_GAMEOVER) begin
          state_d  = ST_LOAD;
          active_d = ID_GAMEOVER;
          slot_d   = 2'd0;
          note_d   = '0;
        end else if (note_q == NW'(NOTE_CYCLES - 1)) begin
          state_d = ST_LOAD;
          slot_d  = slot_q + 2'd1;
          note_d  = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        active_d = ID_NONE;
      end
    endcase
  end

  // Output logic: sample is computed from next-cycle state so it lands registered.
  always_comb begin
    sample_d = '0;
    if (!mute && state_d == ST_PLAY) sample_d = phase_next ? AMPLITUDE : NEG_AMP;
    busy            = (state_q != ST_IDLE);
    active_id       = active_q;
    write_audio_out = audio_out_allowed;
    sample          = sample_q;
  end

  // State, pending, sequencing and sample registers.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      active_q  <= ID_NONE;
      slot_q    <= 2'd0;
      note_q    <= '0;
      pending_q <= 3'b000;
      sample_q  <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      slot_q    <= slot_d;
      note_q    <= note_d;
      pending_q <= pending_d;
      sample_q  <= sample_d;
    end
  end

  sfx_tone_gen u_tone (
    .CLOCK_50       (CLOCK_50),
    .reset          (reset),
    .clear          (tone_clear),
    .load           (tone_load),
    .enable         (tone_enable),
    .half_period_in (rom_half),
    .phase_next     (phase_next)
  );

endmodule

// File: tb/tb_dino_sfx_sequencer.sv
// Directed bench for dino_sfx_sequencer: a short-note instance for sequencing
// and a long-note instance to observe a real 450 Hz half-period toggle.
module tb_dino_sfx_sequencer;

  localparam int          NC      = 50;
  localparam int          NC_LONG = 60000;
  localparam logic [31:0] AMP     = 32'd10000000;
  localparam logic [31:0] NAMP    = 32'hFF67_6980;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1, mute = 1'b0;
  logic        req_jump = 1'b0, req_point = 1'b0, req_gameover = 1'b0;
  logic        audio_out_allowed = 1'b0;
  logic [31:0] sample;
  logic        write_audio_out, busy;
  logic [1:0]  active_id;

  logic        reset_l = 1'b1, req_jump_l = 1'b0;
  logic [31:0] sample_l;
  logic        write_l, busy_l;
  logic [1:0]  active_l;

  int n_checks = 0;
  int n_fail   = 0;
  bit muted    = 1'b0;

  always #10 CLOCK_50 = ~CLOCK_50;

  dino_sfx_sequencer #(.AMPLITUDE(AMP), .NOTE_CYCLES(NC)) dut (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset),
    .mute              (mute),
    .req_jump          (req_jump),
    .req_point         (req_point),
    .req_gameover      (req_gameover),
    .audio_out_allowed (audio_out_allowed),
    .sample            (sample),
    .write_audio_out   (write_audio_out),
    .busy              (busy),
    .active_id         (active_id)
  );

  dino_sfx_sequencer #(.AMPLITUDE(AMP), .NOTE_CYCLES(NC_LONG)) dut_long (
    .CLOCK_50          (CLOCK_50),
    .reset             (reset_l),
    .mute              (1'b0),
    .req_jump          (req_jump_l),
    .req_point         (1'b0),
    .req_gameover      (1'b0),
    .audio_out_allowed (1'b1),
    .sample            (sample_l),
    .write_audio_out   (write_l),
    .busy              (busy_l),
    .active_id         (active_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Called on a LOAD cycle for slot s; leaves the bench on the following LOAD cycle.
  // A request vector may be pulsed at PLAY offset pulse_at.
  task automatic play_note(input string tag, input logic [1:0] id, input logic [17:0] half,
                           input logic [2:0] pulse_vec, input int pulse_at);
    logic [31:0] exp_s;
    exp_s = muted ? 32'd0 : AMP;
    check({tag, ".load_id"}, 32'(active_id), 32'(id));
    check({tag, ".load_busy"}, 32'(busy), 32'd1);
    check({tag, ".load_sample"}, sample, 32'd0);
    tick();
    check({tag, ".half"}, 32'(dut.u_tone.half_q), 32'(half));
    check({tag, ".first_sample"}, sample, exp_s);
    check({tag, ".play_id"}, 32'(active_id), 32'(id));
    for (int k = 0; k < NC - 1; k++) begin
      {req_gameover, req_point, req_jump} = (k == pulse_at) ? pulse_vec : 3'b000;
      tick();
      {req_gameover, req_point, req_jump} = 3'b000;
    end
    check({tag, ".last_sample"}, sample, exp_s);
    tick();
  endtask

  task automatic play_effect(input string tag, input logic [1:0] id, input int n,
                             input logic [17:0] h0, input logic [17:0] h1, input logic [17:0] h2);
    play_note({tag, ".n0"}, id, h0, 3'b000, -1);
    if (n > 1) play_note({tag, ".n1"}, id, h1, 3'b000, -1);
    if (n > 2) play_note({tag, ".n2"}, id, h2, 3'b000, -1);
    check({tag, ".end_busy"}, 32'(busy), 32'd1);
    check({tag, ".end_id"}, 32'(active_id), 32'(id));
  endtask

  task automatic pulse(input logic [2:0] v);
    {req_gameover, req_point, req_jump} = v;
    tick();
    {req_gameover, req_point, req_jump} = 3'b000;
    check("pend.busy", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".id"}, 32'(active_id), 32'd0);
    check({tag, ".sample"}, sample, 32'd0);
  endtask

  initial begin
    #(64'd20 * 64'd90000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    reset   = 1'b0;
    reset_l = 1'b0;
    fork
      begin : long_branch
        req_jump_l = 1'b1;
        tick();
        req_jump_l = 1'b0;
        tick();
        tick();
        check("long.busy", 32'(busy_l), 32'd1);
        check("long.id", 32'(active_l), 32'd1);
        check("long.first", sample_l, AMP);
        repeat (55554) tick();
        check("long.before_toggle", sample_l, AMP);
        tick();
        check("long.after_toggle", sample_l, NAMP);
        check("long.write", 32'(write_l), 32'd1);
        reset_l = 1'b1;
      end
      begin : main_branch
        // Reset and idle.
        expect_idle("reset");
        begin
          bit bad_idle = 1'b0;
          for (int i = 0; i < 1000; i++) begin
            audio_out_allowed = i[0];
            tick();
            if (busy !== 1'b0 || active_id !== 2'd0 || sample !== 32'd0 ||
                write_audio_out !== audio_out_allowed) bad_idle = 1'b1;
          end
          check("idle.1000", 32'(bad_idle), 32'd0);
        end
        audio_out_allowed = 1'b1;
        #1 check("write.hi", 32'(write_audio_out), 32'd1);
        audio_out_allowed = 1'b0;
        #1 check("write.lo", 32'(write_audio_out), 32'd0);

        // Single jump.
        pulse(3'b001);
        play_effect("jump", 2'd1, 2, 18'd55555, 18'd55555, 18'd0);
        tick();
        expect_idle("jump.done");

        // Simultaneous requests: gameover, point, jump back-to-back.
        pulse(3'b111);
        play_effect("all.go", 2'd3, 3, 18'd56818, 18'd75757, 18'd113636);
        tick();
        play_effect("all.pt", 2'd2, 2, 18'd37878, 18'd28409, 18'd0);
        tick();
        play_effect("all.jp", 2'd1, 2, 18'd55555, 18'd55555, 18'd0);
        tick();
        expect_idle("all.done");

        // Gameover preempts a jump; the jump is dropped.
        pulse(3'b001);
        check("pre.jump_id", 32'(active_id), 32'd1);
        tick();
        repeat (10) tick();
        req_gameover = 1'b1;
        tick();
        req_gameover = 1'b0;
        check("pre.go_id", 32'(active_id), 32'd3);
        play_effect("pre.go", 2'd3, 3, 18'd56818, 18'd75757, 18'd113636);
        tick();
        expect_idle("pre.done");
        repeat (NC) tick();
        expect_idle("pre.no_resume");

        // Point during a jump waits for the jump to complete.
        pulse(3'b001);
        play_note("jpt.n0", 2'd1, 18'd55555, 3'b010, 7);
        play_note("jpt.n1", 2'd1, 18'd55555, 3'b000, -1);
        check("jpt.end_id", 32'(active_id), 32'd1);
        tick();
        play_effect("jpt.pt", 2'd2, 2, 18'd37878, 18'd28409, 18'd0);
        tick();
        expect_idle("jpt.done");

        // Muted jump re-requested during play replays once.
        mute  = 1'b1;
        muted = 1'b1;
        pulse(3'b001);
        play_note("rr.a0", 2'd1, 18'd55555, 3'b001, 20);
        play_note("rr.a1", 2'd1, 18'd55555, 3'b000, -1);
        check("rr.a_end", 32'(active_id), 32'd1);
        tick();
        play_effect("rr.b", 2'd1, 2, 18'd55555, 18'd55555, 18'd0);
        tick();
        expect_idle("rr.done");
        mute  = 1'b0;
        muted = 1'b0;

        // Reset mid-effect with a jump pending.
        pulse(3'b001);
        tick();
        check("rst.play", sample, AMP);
        req_jump = 1'b1;
        tick();
        req_jump = 1'b0;
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_idle("rst.now");
        begin
          bit woke = 1'b0;
          for (int i = 0; i < 3 * NC; i++) begin
            tick();
            if (busy !== 1'b0) woke = 1'b1;
          end
          check("rst.stay_idle", 32'(woke), 32'd0);
        end
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
